// File: rtl/gmii_frame_checker.sv
// GMII receive frame checker: strips preamble/SFD, streams payload with SOF/EOF,
// checks FCS residue and frame length, and keeps saturating good/bad frame counters.
module gmii_frame_checker #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518,
   parameter int PRE_MAX = 15
) (
   input  logic        reset_n,
   input  logic        gmii_rxc,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rxdv,
   input  logic        gmii_rxer,
   output logic        dout_vld,
   output logic [7:0]  dout,
   output logic        dout_sof,
   output logic        dout_eof,
   output logic        frame_done,
   output logic        frame_ok,
   output logic [15:0] frame_len,
   output logic        err_crc,
   output logic        err_sfd,
   output logic        err_rxer,
   output logic        err_len,
   output logic [15:0] cnt_good,
   output logic [15:0] cnt_bad
);

   localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L   = 16'(MAX_LEN);
   localparam logic [7:0]  PRE_L   = 8'(PRE_MAX);
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_DROP, S_DONE} state_t;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  rxd_q, rxd_d;
   logic        rxdv_q, rxdv_d, rxer_q, rxer_d;
   logic [7:0]  pre_cnt_q, pre_cnt_d;
   logic [15:0] len_q, len_d;
   logic [31:0] crc_q, crc_d;
   logic [7:0]  hold_q, hold_d;
   logic        hold_vld_q, hold_vld_d, hold_sof_q, hold_sof_d;
   logic        sfd_bad_q, sfd_bad_d, rxer_seen_q, rxer_seen_d;
   logic        dout_vld_q, dout_vld_d, dout_sof_q, dout_sof_d, dout_eof_q, dout_eof_d;
   logic [7:0]  dout_q, dout_d;
   logic        frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
   logic [15:0] frame_len_q, frame_len_d;
   logic        err_crc_q, err_crc_d, err_sfd_q, err_sfd_d;
   logic        err_rxer_q, err_rxer_d, err_len_q, err_len_d;
   logic [15:0] cnt_good_q, cnt_good_d, cnt_bad_q, cnt_bad_d;
   logic        fin, crc_bad, len_bad;

   always_comb begin
      rxd_d        = gmii_rxd;
      rxdv_d       = gmii_rxdv;
      rxer_d       = gmii_rxer;
      state_d      = state_q;
      pre_cnt_d    = pre_cnt_q;
      len_d        = len_q;
      crc_d        = crc_q;
      hold_d       = hold_q;
      hold_vld_d   = hold_vld_q;
      hold_sof_d   = hold_sof_q;
      sfd_bad_d    = sfd_bad_q;
      rxer_seen_d  = rxer_seen_q | (rxer_q & rxdv_q);
      dout_vld_d   = 1'b0;
      dout_d       = dout_q;
      dout_sof_d   = 1'b0;
      dout_eof_d   = 1'b0;
      frame_done_d = 1'b0;
      frame_ok_d   = frame_ok_q;
      frame_len_d  = frame_len_q;
      err_crc_d    = err_crc_q;
      err_sfd_d    = err_sfd_q;
      err_rxer_d   = err_rxer_q;
      err_len_d    = err_len_q;
      cnt_good_d   = cnt_good_q;
      cnt_bad_d    = cnt_bad_q;
      fin          = 1'b0;
      crc_bad      = 1'b0;
      len_bad      = 1'b0;

      case (state_q)
         // DONE doubles as IDLE so a single idle cycle between frames is enough
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (rxdv_q) begin
               pre_cnt_d   = 8'd1;
               len_d       = '0;
               rxer_seen_d = rxer_q;
               sfd_bad_d   = (rxd_q != 8'h55);
               state_d     = (rxd_q == 8'h55) ? S_PRE : S_DROP;
            end
         end
         S_PRE: begin
            if (!rxdv_q) begin
               sfd_bad_d = 1'b1;
               fin       = 1'b1;
            end else if (rxd_q == 8'h55) begin
               if (pre_cnt_q >= PRE_L) begin
                  sfd_bad_d = 1'b1;
                  state_d   = S_DROP;
               end else begin
                  pre_cnt_d = pre_cnt_q + 8'd1;
               end
            end else if (rxd_q == 8'hD5) begin
               len_d      = '0;
               crc_d      = 32'hFFFFFFFF;
               hold_vld_d = 1'b0;
               state_d    = S_DATA;
            end else begin
               sfd_bad_d = 1'b1;
               state_d   = S_DROP;
            end
         end
         S_DATA: begin
            if (rxdv_q) begin
               if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
               crc_d = crc_byte(crc_q, rxd_q);
               if (hold_vld_q) begin
                  dout_vld_d = 1'b1;
                  dout_d     = hold_q;
                  dout_sof_d = hold_sof_q;
               end
               hold_d     = rxd_q;
               hold_vld_d = 1'b1;
               hold_sof_d = (len_q == 16'd0);
            end else begin
               if (hold_vld_q) begin
                  dout_vld_d = 1'b1;
                  dout_d     = hold_q;
                  dout_sof_d = hold_sof_q;
                  dout_eof_d = 1'b1;
               end
               hold_vld_d = 1'b0;
               fin        = 1'b1;
            end
         end
         S_DROP: if (!rxdv_q) fin = 1'b1;
         default: state_d = S_IDLE;
      endcase

      if (fin) begin
         crc_bad      = ~sfd_bad_d & (crc_q != RESIDUE);
         len_bad      = ~sfd_bad_d & ((len_q < MIN_L) | (len_q > MAX_L));
         state_d      = S_DONE;
         frame_done_d = 1'b1;
         frame_len_d  = len_q;
         err_crc_d    = crc_bad;
         err_sfd_d    = sfd_bad_d;
         err_rxer_d   = rxer_seen_d;
         err_len_d    = len_bad;
         frame_ok_d   = ~(crc_bad | sfd_bad_d | rxer_seen_d | len_bad);
         if (frame_ok_d) begin
            if (cnt_good_q != 16'hFFFF) cnt_good_d = cnt_good_q + 16'd1;
         end else begin
            if (cnt_bad_q != 16'hFFFF) cnt_bad_d = cnt_bad_q + 16'd1;
         end
      end
   end

   always_ff @(posedge gmii_rxc or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         rxd_q        <= '0;
         rxdv_q       <= 1'b0;
         rxer_q       <= 1'b0;
         pre_cnt_q    <= '0;
         len_q        <= '0;
         crc_q        <= 32'hFFFFFFFF;
         hold_q       <= '0;
         hold_vld_q   <= 1'b0;
         hold_sof_q   <= 1'b0;
         sfd_bad_q    <= 1'b0;
         rxer_seen_q  <= 1'b0;
         dout_vld_q   <= 1'b0;
         dout_q       <= '0;
         dout_sof_q   <= 1'b0;
         dout_eof_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_ok_q   <= 1'b0;
         frame_len_q  <= '0;
         err_crc_q    <= 1'b0;
         err_sfd_q    <= 1'b0;
         err_rxer_q   <= 1'b0;
         err_len_q    <= 1'b0;
         cnt_good_q   <= '0;
         cnt_bad_q    <= '0;
      end else begin
         state_q      <= state_d;
         rxd_q        <= rxd_d;
         rxdv_q       <= rxdv_d;
         rxer_q       <= rxer_d;
         pre_cnt_q    <= pre_cnt_d;
         len_q        <= len_d;
         crc_q        <= crc_d;
         hold_q       <= hold_d;
         hold_vld_q   <= hold_vld_d;
         hold_sof_q   <= hold_sof_d;
         sfd_bad_q    <= sfd_bad_d;
         rxer_seen_q  <= rxer_seen_d;
         dout_vld_q   <= dout_vld_d;
         dout_q       <= dout_d;
         dout_sof_q   <= dout_sof_d;
         dout_eof_q   <= dout_eof_d;
         frame_done_q <= frame_done_d;
         frame_ok_q   <= frame_ok_d;
         frame_len_q  <= frame_len_d;
         err_crc_q    <= err_crc_d;
         err_sfd_q    <= err_sfd_d;
         err_rxer_q   <= err_rxer_d;
         err_len_q    <= err_len_d;
         cnt_good_q   <= cnt_good_d;
         cnt_bad_q    <= cnt_bad_d;
      end
   end

   assign dout_vld   = dout_vld_q;
   assign dout       = dout_q;
   assign dout_sof   = dout_sof_q;
   assign dout_eof   = dout_eof_q;
   assign frame_done = frame_done_q;
   assign frame_ok   = frame_ok_q;
   assign frame_len  = frame_len_q;
   assign err_crc    = err_crc_q;
   assign err_sfd    = err_sfd_q;
   assign err_rxer   = err_rxer_q;
   assign err_len    = err_len_q;
   assign cnt_good   = cnt_good_q;
   assign cnt_bad    = cnt_bad_q;

endmodule
